// File: rtl/usb_uart_rx_buffer_if.sv
// CPU-side read path of the USB serial receive buffer: pop/clear strobes
// from the address-decode stage, head byte and status back to it.
interface usb_uart_rx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rd_en;
    logic                  clr_err;
    logic [7:0]            rd_data;
    logic                  data_ready;
    logic                  fifo_full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overrun;
    logic                  frame_err;

    modport master (
        output rd_en, clr_err,
        input  rd_data, data_ready, fifo_full, count, overrun, frame_err
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, data_ready, fifo_full, count, overrun, frame_err
    );
endinterface

// File: rtl/usb_uart_rx_buffer.sv
// 8N1 UART receiver on the USB serial line feeding a circular receive FIFO
// that the CPU drains one byte per data-register read.
module usb_uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 96,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    usb_uart_rx_buffer_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int          CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] IDLE_QUAL = CW'(3);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [2:0]            bit_idx, bit_n;
    logic [7:0]            shreg, shreg_n;
    logic                  push_req, frame_evt;
    logic                  rx_meta, rxs;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  overrun_q, frame_err_q;
    logic                  pop, push_ok, drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        shreg_n   = shreg;
        push_req  = 1'b0;
        frame_evt = 1'b0;
        case (state)
            // Line must read high for several cycles: this flushes the
            // synchroniser's reset value so a line still low is not taken as idle.
            WAIT_IDLE: begin
                if (!rxs) begin
                    cnt_n = '0;
                end else if (cnt == IDLE_QUAL) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            IDLE: begin
                if (!rxs) begin
                    cnt_n   = HALF_M1;
                    state_n = START;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (!rxs) begin
                    cnt_n   = FULL_M1;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    shreg_n = {rxs, shreg[7:1]};
                    cnt_n   = FULL_M1;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (rxs) begin
                    push_req = 1'b1;
                    state_n  = IDLE;
                end else begin
                    frame_evt = 1'b1;
                    state_n   = WAIT_IDLE;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign pop     = bus.rd_en && (fifo_count != '0);
    assign push_ok = push_req && ((fifo_count != FULL_CNT) || pop);
    assign drop    = push_req && !push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem         <= '{default: '0};
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (DEPTH_LOG2+1)'(1);
                2'b01:   fifo_count <= fifo_count - (DEPTH_LOG2+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            overrun_q   <= (overrun_q && !bus.clr_err) || drop;
            frame_err_q <= (frame_err_q && !bus.clr_err) || frame_evt;
        end
    end

    assign bus.rd_data    = mem[rd_ptr];
    assign bus.count      = fifo_count;
    assign bus.data_ready = (fifo_count != '0);
    assign bus.fifo_full  = (fifo_count == FULL_CNT);
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_usb_uart_rx_buffer.sv
// Bench for usb_uart_rx_buffer: directed 8N1 frames, expected bytes queued at
// send time and compared by a monitor on every pop.
module tb_usb_uart_rx_buffer;
    localparam int BIT = 96;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cyc = -1;
    int lat      = 0;
    logic prev_ready = 1'b0;
    logic [7:0] exp_q [$];

    usb_uart_rx_buffer_if #(.DEPTH_LOG2(4)) bus ();

    usb_uart_rx_buffer #(.CLKS_PER_BIT(BIT), .DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pop monitor: every accepted pop must return the oldest outstanding byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && bus.rd_en && bus.data_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_data: popped %02h, required no byte (nothing outstanding)", bus.rd_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: popped %02h, required %02h", bus.rd_data, e);
                end
            end
        end
        if (bus.data_ready && !prev_ready) rise_cyc = cyc;
        prev_ready = bus.data_ready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(BIT);
        end
        rxd = stop;
        idle(BIT);
    endtask

    task automatic pop_one();
        bus.rd_en = 1'b1;
        idle(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},      bus.count, 0);
        check({tag, "_data_ready"}, bus.data_ready, 0);
        check({tag, "_fifo_full"},  bus.fifo_full, 0);
        check({tag, "_rd_data"},    bus.rd_data, 0);
        check({tag, "_overrun"},    bus.overrun, 0);
        check({tag, "_frame_err"},  bus.frame_err, 0);
    endtask

    initial begin
        int t0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        check_reset_outputs("reset");
        idle(20);

        // Frame 0x5A and head latency relative to the start edge
        exp_q.push_back(8'h5A);
        rise_cyc = -1;
        t0 = cyc;
        send_bits(8'h5A, 1'b1);
        idle(10);
        lat = rise_cyc - t0;
        check("ready_latency_in_window", (lat >= 900 && lat <= 930), 1);
        check("5a_count", bus.count, 1);
        check("5a_data_ready", bus.data_ready, 1);
        check("5a_rd_data", bus.rd_data, 8'h5A);
        pop_one();
        check("5a_count_after_pop", bus.count, 0);
        check("5a_ready_after_pop", bus.data_ready, 0);

        // Pop on empty is ignored
        pop_one();
        check("empty_pop_count", bus.count, 0);
        check("empty_pop_ready", bus.data_ready, 0);

        // Glitch shorter than half a bit
        rxd = 1'b0;
        idle(20);
        rxd = 1'b1;
        idle(300);
        check("glitch_count", bus.count, 0);
        check("glitch_frame_err", bus.frame_err, 0);

        // Framing error, line held low, then a good frame
        send_bits(8'h33, 1'b0);
        idle(500);
        rxd = 1'b1;
        idle(200);
        check("ferr_flag", bus.frame_err, 1);
        check("ferr_not_pushed", bus.count, 0);
        exp_q.push_back(8'h44);
        send_bits(8'h44, 1'b1);
        idle(10);
        check("ferr_next_count", bus.count, 1);
        pop_one();
        check("ferr_next_drained", bus.count, 0);
        bus.clr_err = 1'b1;
        idle(1);
        bus.clr_err = 1'b0;
        check("ferr_cleared", bus.frame_err, 0);

        // Fill to 16 then overrun on the 17th
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_bits(8'(i), 1'b1);
            idle(10);
            if (i == 15) begin
                check("full_after_16", bus.fifo_full, 1);
                check("no_overrun_at_16", bus.overrun, 0);
            end
        end
        check("overrun_after_17", bus.overrun, 1);
        check("count_after_17", bus.count, 16);
        check("full_after_17", bus.fifo_full, 1);
        bus.clr_err = 1'b1;
        idle(1);
        bus.clr_err = 1'b0;
        check("overrun_cleared", bus.overrun, 0);

        // Full FIFO, pop exactly in the push cycle of 0xA5
        exp_q.push_back(8'hA5);
        fork
            send_bits(8'hA5, 1'b1);
            begin
                repeat (lat - 1) @(posedge clk);
                #1 bus.rd_en = 1'b1;
                @(posedge clk);
                #1 bus.rd_en = 1'b0;
            end
        join
        idle(10);
        check("simul_count", bus.count, 16);
        check("simul_overrun", bus.overrun, 0);
        check("simul_full", bus.fifo_full, 1);
        repeat (16) pop_one();
        check("drain_count", bus.count, 0);
        check("drain_ready", bus.data_ready, 0);
        check("drain_outstanding", exp_q.size(), 0);

        // Reset during bit 3 of an all-low frame with a byte buffered
        exp_q.push_back(8'h11);
        send_bits(8'h11, 1'b1);
        idle(10);
        check("pre_reset_count", bus.count, 1);
        rxd = 1'b0;
        idle(BIT * 4 + BIT / 2);
        rst = 1'b1;
        exp_q.delete();
        idle(3);
        rst = 1'b0;
        idle(1);
        check_reset_outputs("midframe_reset");
        idle(1500);
        check("held_low_count", bus.count, 0);
        check("held_low_frame_err", bus.frame_err, 0);
        rxd = 1'b1;
        idle(200);
        exp_q.push_back(8'h7E);
        send_bits(8'h7E, 1'b1);
        idle(10);
        check("7e_count", bus.count, 1);
        check("7e_rd_data", bus.rd_data, 8'h7E);
        pop_one();
        check("7e_drained", bus.count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
